// File: rtl/hm2_gpio_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module   : hm2_gpio_bridge_if
//  Brief    : hostmot2-side I/O bus and arming handshake of the GPIO bridge.
//  Revision : 1.0 - initial release
// ============================================================================
interface hm2_gpio_bridge_if #(
    parameter int IO_WIDTH = 72
);
    logic                arm;
    logic                armed;
    logic [IO_WIDTH-1:0] io_out;
    logic [IO_WIDTH-1:0] io_oe;
    logic [IO_WIDTH-1:0] io_in;

    modport master (
        output arm, io_out, io_oe,
        input  armed, io_in
    );

    modport slave (
        input  arm, io_out, io_oe,
        output armed, io_in
    );
endinterface
`default_nettype wire

// File: rtl/hm2_gpio_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : hm2_gpio_bridge
//  Brief    : hostmot2 <-> expansion header I/O stage with arming interlock,
//             input synchronizers and optional glitch filter
//             (enabled by defining GPIO_GLITCH_FILTER_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module hm2_gpio_bridge #(
    parameter int IO_WIDTH          = 72,
    parameter int NUM_GPIO          = 2,
    parameter int GPIO_WIDTH        = 36,
    parameter int MUX_GPIO_IO_WIDTH = 36,
    parameter int SYNC_STAGES       = 2,
    parameter int FILTER_CYCLES     = 4,
    parameter int ARM_CYCLES        = 1024
) (
    input  wire logic                             clk,
    input  wire logic                             reset,
    hm2_gpio_bridge_if.slave                      bus,
    output logic [NUM_GPIO*GPIO_WIDTH-1:0]        gpio_out,
    output logic [NUM_GPIO*GPIO_WIDTH-1:0]        gpio_oe,
    input  wire logic [NUM_GPIO*GPIO_WIDTH-1:0]   gpio_in
);
    localparam int c_PIN_W     = NUM_GPIO * GPIO_WIDTH;
    localparam int c_ARM_CNT_W = $clog2(ARM_CYCLES) + 1;
    localparam logic [c_ARM_CNT_W-1:0] c_ARM_LAST = c_ARM_CNT_W'(ARM_CYCLES - 1);

    if (SYNC_STAGES < 2 || FILTER_CYCLES < 1 || ARM_CYCLES < 1 ||
        MUX_GPIO_IO_WIDTH > GPIO_WIDTH || IO_WIDTH > NUM_GPIO * MUX_GPIO_IO_WIDTH) begin : g_bad_param
        $error("hm2_gpio_bridge: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_SAFE  = 2'd0,
        S_HOLD  = 2'd1,
        S_ARMED = 2'd2
    } state_t;

    state_t                   r_state;
    logic [c_ARM_CNT_W-1:0]   r_arm_cnt;
    logic                     r_armed;
    logic [c_PIN_W-1:0]       r_gpio_oe;
    logic [c_PIN_W-1:0]       r_gpio_out;
    logic [c_PIN_W-1:0]       w_map_oe;
    logic [c_PIN_W-1:0]       w_map_out;
    logic [c_PIN_W-1:0]       w_synced;
    logic [c_PIN_W-1:0]       w_cond;
    logic                     w_drive;

    // Unmapped header pins are tied low so they can never be driven.
    for (genvar gh = 0; gh < NUM_GPIO; gh++) begin : g_hdr
        for (genvar gp = 0; gp < GPIO_WIDTH; gp++) begin : g_pin
            if (gp < MUX_GPIO_IO_WIDTH && (gh * MUX_GPIO_IO_WIDTH + gp) < IO_WIDTH) begin : g_mapped
                assign w_map_oe[gh*GPIO_WIDTH+gp]              = bus.io_oe[gh*MUX_GPIO_IO_WIDTH+gp];
                assign w_map_out[gh*GPIO_WIDTH+gp]             = bus.io_out[gh*MUX_GPIO_IO_WIDTH+gp];
                assign bus.io_in[gh*MUX_GPIO_IO_WIDTH+gp]      = w_cond[gh*GPIO_WIDTH+gp];
            end else begin : g_unmapped
                assign w_map_oe[gh*GPIO_WIDTH+gp]  = 1'b0;
                assign w_map_out[gh*GPIO_WIDTH+gp] = 1'b0;
            end
        end
    end

    // Outputs follow the current state and the live arm level, so a dropped
    // arm blanks the pins on the very edge that sees it.
    assign w_drive = (r_state == S_ARMED) && bus.arm;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_SAFE;
            r_arm_cnt  <= '0;
            r_armed    <= 1'b0;
            r_gpio_oe  <= '0;
            r_gpio_out <= '0;
        end else begin
            r_gpio_oe  <= w_drive ? w_map_oe  : '0;
            r_gpio_out <= w_drive ? w_map_out : '0;
            case (r_state)
                S_SAFE: begin
                    if (bus.arm) begin
                        r_state   <= S_HOLD;
                        r_arm_cnt <= '0;
                    end
                end
                S_HOLD: begin
                    if (!bus.arm) begin
                        r_state <= S_SAFE;
                    end else if (r_arm_cnt == c_ARM_LAST) begin
                        r_state <= S_ARMED;
                        r_armed <= 1'b1;
                    end else begin
                        r_arm_cnt <= r_arm_cnt + 1'b1;
                    end
                end
                S_ARMED: begin
                    if (!bus.arm) begin
                        r_state <= S_SAFE;
                        r_armed <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_SAFE;
                    r_armed <= 1'b0;
                end
            endcase
        end
    end

    logic [c_PIN_W-1:0] r_sync [SYNC_STAGES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
        end else begin
            r_sync[0] <= gpio_in;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
    end

    assign w_synced = r_sync[SYNC_STAGES-1];

`ifdef GPIO_GLITCH_FILTER_EN
    localparam int c_FLT_CNT_W = $clog2(FILTER_CYCLES) + 1;
    localparam logic [c_FLT_CNT_W-1:0] c_FLT_LAST = c_FLT_CNT_W'(FILTER_CYCLES - 1);

    // A pin only flips after FILTER_CYCLES consecutive disagreeing samples.
    for (genvar gf = 0; gf < c_PIN_W; gf++) begin : g_filt
        logic [c_FLT_CNT_W-1:0] r_fcnt;
        logic                   r_filt;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_fcnt <= '0;
                r_filt <= 1'b0;
            end else if (w_synced[gf] == r_filt) begin
                r_fcnt <= '0;
            end else if (r_fcnt == c_FLT_LAST) begin
                r_filt <= w_synced[gf];
                r_fcnt <= '0;
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end

        assign w_cond[gf] = r_filt;
    end
`else
    assign w_cond = w_synced;
`endif

    assign gpio_oe   = r_gpio_oe;
    assign gpio_out  = r_gpio_out;
    assign bus.armed = r_armed;

endmodule
`default_nettype wire

// File: tb/tb_hm2_gpio_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hm2_gpio_bridge
//  Brief    : self-checking bench for hm2_gpio_bridge (behavioural model plus
//             directed literal checks).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hm2_gpio_bridge;
    localparam int IOW = 72;
    localparam int NG  = 2;
    localparam int GW  = 36;
    localparam int M   = 36;
    localparam int SS  = 2;
    localparam int FC  = 4;
    localparam int AC  = 16;
    localparam int W   = NG * GW;

    logic         clk;
    logic         reset;
    logic [W-1:0] gpio_out;
    logic [W-1:0] gpio_oe;
    logic [W-1:0] gpio_in;

    hm2_gpio_bridge_if #(.IO_WIDTH(IOW)) bus ();

    hm2_gpio_bridge #(
        .IO_WIDTH(IOW), .NUM_GPIO(NG), .GPIO_WIDTH(GW), .MUX_GPIO_IO_WIDTH(M),
        .SYNC_STAGES(SS), .FILTER_CYCLES(FC), .ARM_CYCLES(AC)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .gpio_out(gpio_out), .gpio_oe(gpio_oe), .gpio_in(gpio_in)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        else n_pass++;
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [W-1:0] map_hdr(input logic [IOW-1:0] v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < IOW; i++) r[(i / M) * GW + (i % M)] = v[i];
        return r;
    endfunction

    function automatic logic [IOW-1:0] unmap_hdr(input logic [W-1:0] v);
        logic [IOW-1:0] r = '0;
        for (int i = 0; i < IOW; i++) r[i] = v[(i / M) * GW + (i % M)];
        return r;
    endfunction

    int             run;       // consecutive edges that sampled arm high
    logic           m_armed;
    logic [W-1:0]   m_oe, m_out, m_filt;
    logic [IOW-1:0] m_io_in;
    logic [W-1:0]   samp [8];  // samp[k] = gpio_in sampled k edges ago

    task automatic model_step();
        logic [W-1:0] and_w, or_w;
        if (reset) begin
            run = 0; m_armed = 1'b0; m_oe = '0; m_out = '0; m_filt = '0;
            for (int k = 0; k < 8; k++) samp[k] = '0;
        end else begin
            m_oe  = (m_armed && bus.arm) ? map_hdr(bus.io_oe)  : '0;
            m_out = (m_armed && bus.arm) ? map_hdr(bus.io_out) : '0;
            run = bus.arm ? ((run > AC) ? run : run + 1) : 0;
            m_armed = (run > AC);
            for (int k = 7; k > 0; k--) samp[k] = samp[k-1];
            samp[0] = gpio_in;
            // Filter: a value passes once the last FC synced samples all agree.
            and_w = '1; or_w = '0;
            for (int k = SS; k < SS + FC; k++) begin
                and_w &= samp[k];
                or_w  |= samp[k];
            end
            m_filt = and_w | (m_filt & or_w);
        end
`ifdef GPIO_GLITCH_FILTER_EN
        m_io_in = unmap_hdr(m_filt);
`else
        m_io_in = unmap_hdr(samp[SS-1]);
`endif
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            chk("cyc_gpio_oe",  gpio_oe,       m_oe);
            chk("cyc_gpio_out", gpio_out,      m_out);
            chk("cyc_armed",    W'(bus.armed), W'(m_armed));
            chk("cyc_io_in",    W'(bus.io_in), W'(m_io_in));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [W-1:0] exp40;
    logic [W-1:0] pats [4];

    initial begin
        reset = 1'b1; bus.arm = 1'b0; bus.io_oe = '1; bus.io_out = '1; gpio_in = '0;
        exp40 = '0; exp40[40] = 1'b1;
        pats[0] = 72'h123456789ABCDEF012;
        pats[1] = 72'hFFFFFFFFFFFFFFFFFF;
        pats[2] = 72'h000000000000000000;
        pats[3] = 72'hA5A5A5A5A5A5A5A5A5;

        tick(3);
        reset = 1'b0;
        tick(100);
        chk("safe_oe",    gpio_oe,       72'h0);
        chk("safe_out",   gpio_out,      72'h0);
        chk("safe_armed", W'(bus.armed), 72'h0);

        // Arm with only bit 40 enabled.
        bus.io_oe = '0; bus.io_out = '0; bus.io_oe[40] = 1'b1; bus.io_out[40] = 1'b1;
        bus.arm = 1'b1;
        for (int j = 1; j <= 18; j++) begin
            tick(1);
            if (j == 16) chk("arm_e15_armed", W'(bus.armed), 72'h0);
            if (j == 17) begin
                chk("arm_e16_armed", W'(bus.armed), 72'h1);
                chk("arm_e16_oe",    gpio_oe,       72'h0);
            end
            if (j == 18) begin
                chk("arm_e17_oe",  gpio_oe,  exp40);
                chk("arm_e17_out", gpio_out, exp40);
            end
        end

        for (int k = 0; k < 4; k++) begin
            bus.io_out = pats[k]; bus.io_oe = ~pats[k];
            tick(1);
            chk("vec_out", gpio_out, pats[k]);
            chk("vec_oe",  gpio_oe,  ~pats[k]);
        end

        bus.arm = 1'b0;
        tick(1);
        chk("drop_oe",  gpio_oe,  72'h0);
        chk("drop_out", gpio_out, 72'h0);
        tick(1);
        chk("drop_armed", W'(bus.armed), 72'h0);

        // One-cycle arm glitch during HOLD restarts the count.
        bus.arm = 1'b1;
        tick(10);
        bus.arm = 1'b0;
        tick(1);
        bus.arm = 1'b1;
        for (int j = 1; j <= 17; j++) begin
            tick(1);
            if (j == 7)  chk("glitch_r6_armed",  W'(bus.armed), 72'h0);
            if (j == 16) chk("glitch_r15_armed", W'(bus.armed), 72'h0);
            if (j == 17) chk("glitch_r16_armed", W'(bus.armed), 72'h1);
        end

        // Asynchronous reset while driving.
        bus.io_oe = '1; bus.io_out = pats[3];
        tick(2);
        chk("pre_rst_oe", gpio_oe, 72'hFFFFFFFFFFFFFFFFFF);
        #2 reset = 1'b1;
        #1;
        chk("arst_oe",    gpio_oe,       72'h0);
        chk("arst_out",   gpio_out,      72'h0);
        chk("arst_armed", W'(bus.armed), 72'h0);
        tick(2);
        reset = 1'b0;

        // Reset mid-HOLD, then count must start over.
        tick(5);
        #2 reset = 1'b1;
        #1;
        chk("hold_rst_armed", W'(bus.armed), 72'h0);
        tick(2);
        reset = 1'b0;
        for (int j = 1; j <= 17; j++) begin
            tick(1);
            if (j == 16) chk("rearm_e15_armed", W'(bus.armed), 72'h0);
            if (j == 17) chk("rearm_e16_armed", W'(bus.armed), 72'h1);
        end
        bus.arm = 1'b0;
        tick(2);

`ifdef GPIO_GLITCH_FILTER_EN
        gpio_in[5] = 1'b1;
        tick(3);
        gpio_in[5] = 1'b0;
        for (int j = 0; j < 10; j++) begin
            tick(1);
            chk("short_pulse_io5", W'(bus.io_in[5]), 72'h0);
        end
        gpio_in[5] = 1'b1;
        tick(5);
        chk("rise5_io5", W'(bus.io_in[5]), 72'h0);
        tick(1);
        chk("rise6_io5", W'(bus.io_in[5]), 72'h1);
        gpio_in[5] = 1'b0;
        tick(5);
        chk("fall5_io5", W'(bus.io_in[5]), 72'h1);
        tick(1);
        chk("fall6_io5", W'(bus.io_in[5]), 72'h0);
`else
        gpio_in[70] = 1'b1;
        tick(1);
        chk("step1_io70", W'(bus.io_in[70]), 72'h0);
        tick(1);
        chk("step2_io70", W'(bus.io_in[70]), 72'h1);
        gpio_in[5] = 1'b1;
        tick(1);
        gpio_in[5] = 1'b0;
        tick(1);
        chk("pulse_io5_hi", W'(bus.io_in[5]), 72'h1);
        tick(1);
        chk("pulse_io5_lo", W'(bus.io_in[5]), 72'h0);
`endif

        for (int k = 0; k < 4; k++) begin
            gpio_in = pats[k];
            tick(8);
            chk("in_vec", W'(bus.io_in), pats[k]);
        end
        gpio_in = '0;
        tick(8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
